// File: rtl/rr_out_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_out_arbiter_pkg
// Shared router definitions: input-port index constants, the default number of
// requesting ports and the output-arbiter state encoding.
// -----------------------------------------------------------------------------
package rr_out_arbiter_pkg;

    localparam int NPORTS  = 5;

    localparam int P_LOCAL = 0;
    localparam int P_NORTH = 1;
    localparam int P_EAST  = 2;
    localparam int P_SOUTH = 3;
    localparam int P_WEST  = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/rr_out_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational circular priority encoder. Scans req & ~mask starting
// at index ptr (ptr, ptr+1, ... wrapping modulo NPORTS) and reports the first
// set bit both as a one-hot vector and as a binary index.
//
// Ports
//   req    [NPORTS-1:0]  request vector
//   mask   [NPORTS-1:0]  1 = exclude this input from the scan
//   ptr    [PW-1:0]      highest-priority index (must be < NPORTS)
//   onehot [NPORTS-1:0]  one-hot winner, all-zero when nothing is eligible
//   index  [PW-1:0]      binary winner index, 0 when nothing is eligible
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NPORTS = 5,
    parameter int PW     = 3
) (
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] mask,
    input  logic [PW-1:0]     ptr,
    output logic [NPORTS-1:0] onehot,
    output logic [PW-1:0]     index
);

    localparam logic [PW:0] NP_W = (PW+1)'(NPORTS);

    logic [NPORTS-1:0] eligible_s;
    logic [PW:0]       sum_s;
    logic [PW-1:0]     pos_s;
    logic              hit_s;
    logic              found_s;

    assign eligible_s = req & ~mask;

    // Walk the inputs in circular priority order; only the first eligible one wins.
    always_comb begin
        onehot  = {NPORTS{1'b0}};
        index   = {PW{1'b0}};
        sum_s   = {(PW+1){1'b0}};
        pos_s   = {PW{1'b0}};
        hit_s   = 1'b0;
        found_s = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            sum_s         = {1'b0, ptr} + (PW+1)'(k);
            pos_s         = (sum_s >= NP_W) ? PW'(sum_s - NP_W) : sum_s[PW-1:0];
            hit_s         = eligible_s[pos_s] & ~found_s;
            onehot[pos_s] = hit_s;
            index         = hit_s ? pos_s : index;
            found_s       = found_s | hit_s;
        end
    end

endmodule

// File: rtl/rr_out_arbiter.sv
// -----------------------------------------------------------------------------
// rr_out_arbiter
// Round-robin arbiter for one router output port. Issues a registered one-hot
// grant to one of NPORTS inputs and, in wormhole mode, keeps it until the
// owner's tail flit transfers so packets never interleave on the port.
//
// Build option
//   RR_WORMHOLE_LOCK_EN  defined   : grant held head-through-tail.
//                        undefined : per-flit arbitration, tail ignored.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   req        [NPORTS-1:0] input i holds a flit routed here
//   tail       [NPORTS-1:0] flit presented by input i is a packet tail
//   out_ready  downstream credit available this cycle
//   grant      [NPORTS-1:0] registered one-hot grant (or zero)
//   fire       combinational: owner flit transfers this cycle
//   busy       registered: a packet owns the port
// -----------------------------------------------------------------------------
module rr_out_arbiter #(
    parameter int NPORTS  = rr_out_arbiter_pkg::NPORTS,
    parameter int RST_PTR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] tail,
    input  logic              out_ready,
    output logic [NPORTS-1:0] grant,
    output logic              fire,
    output logic              busy
);

    import rr_out_arbiter_pkg::*;

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    state_e            state_r;
    state_e            state_n_s;
    logic [NPORTS-1:0] grant_r;
    logic [NPORTS-1:0] grant_n_s;
    logic [PW-1:0]     ptr_r;
    logic [PW-1:0]     ptr_n_s;
    logic              busy_r;
    logic              busy_n_s;
    logic [NPORTS-1:0] mask_s;
    logic [NPORTS-1:0] pick_onehot_s;
    logic [PW-1:0]     pick_index_s;
    logic              pick_valid_s;
    logic              fire_s;
    logic              release_s;

    // Explicit wrap: the last input hands priority back to input 0.
    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
        ptr_after = (idx == PW'(NPORTS-1)) ? {PW{1'b0}} : idx + PW'(1);
    endfunction

    // grant_r is zero in IDLE, so fire can only assert for a current owner.
    assign fire_s = (|(grant_r & req)) & out_ready;

`ifdef RR_WORMHOLE_LOCK_EN
    logic owner_tail_s;

    assign owner_tail_s = |(grant_r & tail);
    assign release_s    = fire_s & owner_tail_s;
    // The releasing owner may not immediately win again; in IDLE grant_r is zero.
    assign mask_s       = grant_r;
`else
    logic others_s;
    logic unused_tail_s;

    assign unused_tail_s = ^tail;
    assign others_s      = |(req & ~grant_r);
    assign release_s     = fire_s;
    // The owner is excluded only when someone else is waiting for the port.
    assign mask_s        = others_s ? grant_r : {NPORTS{1'b0}};
`endif

    rr_pick #(
        .NPORTS (NPORTS),
        .PW     (PW)
    ) u_pick (
        .req    (req),
        .mask   (mask_s),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .index  (pick_index_s)
    );

    assign pick_valid_s = |pick_onehot_s;

    // Next-state, next-grant and next-pointer selection.
    always_comb begin
        state_n_s = state_r;
        grant_n_s = grant_r;
        ptr_n_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_n_s = ST_LOCKED;
                    grant_n_s = pick_onehot_s;
                    ptr_n_s   = ptr_after(pick_index_s);
                end else begin
                    state_n_s = ST_IDLE;
                    grant_n_s = {NPORTS{1'b0}};
                end
            end
            ST_LOCKED: begin
                if (release_s && pick_valid_s) begin
                    state_n_s = ST_LOCKED;
                    grant_n_s = pick_onehot_s;
                    ptr_n_s   = ptr_after(pick_index_s);
                end else if (release_s) begin
                    state_n_s = ST_IDLE;
                    grant_n_s = {NPORTS{1'b0}};
                end else begin
                    // Stalled downstream or owner bubble: keep everything.
                    state_n_s = ST_LOCKED;
                    grant_n_s = grant_r;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                grant_n_s = {NPORTS{1'b0}};
                ptr_n_s   = PW'(RST_PTR);
            end
        endcase
        // LOCKED always carries a non-zero grant, so this also equals |grant.
        busy_n_s = (state_n_s == ST_LOCKED);
    end

    // State, grant, pointer and busy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            grant_r <= {NPORTS{1'b0}};
            ptr_r   <= PW'(RST_PTR);
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            grant_r <= grant_n_s;
            ptr_r   <= ptr_n_s;
            busy_r  <= busy_n_s;
        end
    end

    assign grant = grant_r;
    assign busy  = busy_r;
    assign fire  = fire_s;

endmodule

// File: tb/tb_rr_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_out_arbiter
// Self-checking bench for rr_out_arbiter. Directed scenarios plus a random run
// compared against a behavioural model tracking the current owner (or none)
// and the round-robin start index.
// -----------------------------------------------------------------------------
module tb_rr_out_arbiter;

    localparam int NP = 5;
`ifdef RR_WORMHOLE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req;
    logic [NP-1:0] tail;
    logic          out_ready;
    logic [NP-1:0] grant;
    logic          fire;
    logic          busy;

    int   checks = 0;
    int   errors = 0;

    // Behavioural model: owning input (-1 = none) and next priority index.
    int   m_owner = -1;
    int   m_ptr   = 0;
    logic fire_obs;
    logic fire_exp;

    rr_out_arbiter #(.NPORTS(NP), .RST_PTR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .grant     (grant),
        .fire      (fire),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // First requester at or after 'from', circularly; -1 if none.
    function automatic int scan(input logic [NP-1:0] cand, input int from);
        for (int k = 0; k < NP; k++) begin
            if (cand[(from + k) % NP]) return (from + k) % NP;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] exp_grant();
        logic [NP-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_update(input logic [NP-1:0] r, input logic [NP-1:0] t,
                                input logic o, input logic rs);
        logic [NP-1:0] others;
        logic [NP-1:0] cand;
        int w;
        if (!rs) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            w = scan(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_ptr   = (w + 1) % NP;
            end
        end else if (r[m_owner] && o && (!LOCK || t[m_owner])) begin
            others = r;
            others[m_owner] = 1'b0;
            cand = (others != '0) ? others : (LOCK ? '0 : r);
            w = scan(cand, m_ptr);
            m_owner = w;
            if (w >= 0) m_ptr = (w + 1) % NP;
        end
    endtask

    // Drive one cycle, sample fire mid-cycle, advance the model at the edge.
    task automatic step(input logic [NP-1:0] r, input logic [NP-1:0] t,
                        input logic o, input logic rs);
        req = r; tail = t; out_ready = o; rst = rs;
        @(negedge clk);
        fire_obs = fire;
        fire_exp = (m_owner >= 0) && r[m_owner] && o;
        @(posedge clk);
        model_update(r, t, o, rs);
        #1;
    endtask

    task automatic test_reset();
        step(5'b11111, 5'b11111, 1'b1, 1'b0);
        step(5'b11111, 5'b11111, 1'b1, 1'b0);
        checks++;
        if (grant !== 5'b00000) begin errors++; $display("FAIL reset_grant: got %b want %b", grant, 5'b00000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want %b", busy, 1'b0); end
        step(5'b11111, 5'b11111, 1'b0, 1'b1);
        checks++;
        if (grant !== 5'b00001) begin errors++; $display("FAIL reset_first_grant: got %b want %b", grant, 5'b00001); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want %b", busy, 1'b1); end
    endtask

    task automatic test_fairness();
        logic [NP-1:0] seq [4] = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(5'b10101, 5'b11111, 1'b1, 1'b1);
            checks++;
            if (grant !== seq[i]) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", i, grant, seq[i]); end
            checks++;
            if (fire_obs !== (i > 0)) begin errors++; $display("FAIL fair_fire[%0d]: got %b want %b", i, fire_obs, (i > 0)); end
        end
    endtask

    task automatic test_wormhole();
        logic [NP-1:0] lock_tbl [4] = '{5'b00010, 5'b00010, 5'b00010, 5'b00100};
        logic [NP-1:0] flit_tbl [4] = '{5'b00100, 5'b01000, 5'b10000, 5'b00001};
        logic [NP-1:0] want;
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        step(5'b00010, 5'b00000, 1'b1, 1'b1);
        checks++;
        if (grant !== 5'b00010) begin errors++; $display("FAIL worm_head_grant: got %b want %b", grant, 5'b00010); end
        for (int i = 0; i < 4; i++) begin
            step(5'b11111, (i == 3) ? 5'b00010 : 5'b00000, 1'b1, 1'b1);
            want = LOCK ? lock_tbl[i] : flit_tbl[i];
            checks++;
            if (fire_obs !== 1'b1) begin errors++; $display("FAIL worm_fire[%0d]: got %b want 1", i, fire_obs); end
            checks++;
            if (grant !== want) begin errors++; $display("FAIL worm_grant[%0d]: got %b want %b", i, grant, want); end
        end
    endtask

    task automatic test_backpressure();
        logic rdy [6]   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [NP-1:0] want;
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        step(5'b00100, 5'b00000, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(5'b00100, (i == 5) ? 5'b00100 : 5'b00000, rdy[i], 1'b1);
            want = (i == 5 && LOCK) ? 5'b00000 : 5'b00100;
            checks++;
            if (fire_obs !== rdy[i]) begin errors++; $display("FAIL bp_fire[%0d]: got %b want %b", i, fire_obs, rdy[i]); end
            checks++;
            if (grant !== want) begin errors++; $display("FAIL bp_grant[%0d]: got %b want %b", i, grant, want); end
        end
        checks++;
        if (busy !== !LOCK) begin errors++; $display("FAIL bp_busy_end: got %b want %b", busy, !LOCK); end
    endtask

    task automatic test_wrap();
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        step(5'b01000, 5'b00000, 1'b1, 1'b1);
        checks++;
        if (grant !== 5'b01000) begin errors++; $display("FAIL wrap_first: got %b want %b", grant, 5'b01000); end
        step(5'b01011, 5'b01000, 1'b1, 1'b1);
        checks++;
        if (fire_obs !== 1'b1) begin errors++; $display("FAIL wrap_fire: got %b want 1", fire_obs); end
        checks++;
        if (grant !== 5'b00001) begin errors++; $display("FAIL wrap_grant: got %b want %b", grant, 5'b00001); end
    endtask

    task automatic test_midreset();
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        step(5'b00010, 5'b00000, 1'b1, 1'b1);
        step(5'b00010, 5'b00000, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
        step(5'b00010, 5'b00000, 1'b1, 1'b0);
        checks++;
        if (grant !== 5'b00000) begin errors++; $display("FAIL midrst_grant: got %b want %b", grant, 5'b00000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        step(5'b00100, 5'b00000, 1'b0, 1'b1);
        checks++;
        if (grant !== 5'b00100) begin errors++; $display("FAIL midrst_regrant: got %b want %b", grant, 5'b00100); end
        // Pointer was 3 before this reset; after it, input 2 must beat input 4.
        step(5'b00100, 5'b00000, 1'b0, 1'b0);
        step(5'b10100, 5'b00000, 1'b0, 1'b1);
        checks++;
        if (grant !== 5'b00100) begin errors++; $display("FAIL midrst_ptr: got %b want %b", grant, 5'b00100); end
    endtask

    task automatic test_random();
        logic [31:0]   rv;
        logic [NP-1:0] g_exp;
        step(5'b00000, 5'b00000, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            rv = $urandom;
            step(rv[4:0], rv[12:8], ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
            g_exp = exp_grant();
            checks++;
            if (grant !== g_exp) begin errors++; $display("FAIL rand_grant[%0d]: got %b want %b", n, grant, g_exp); end
            checks++;
            if (busy !== (m_owner >= 0)) begin errors++; $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, (m_owner >= 0)); end
            checks++;
            if (fire_obs !== fire_exp) begin errors++; $display("FAIL rand_fire[%0d]: got %b want %b", n, fire_obs, fire_exp); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req = '0; tail = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_fairness();
        test_wormhole();
        test_backpressure();
        test_wrap();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
